cache_arbiter: RTL and testbench



---
 rtl/arb_types.sv | 18 +
 rtl/arb_checker.sv | 15 +
 rtl/arb_select.sv | 37 +++
 rtl/cache_arbiter.sv | 145 ++++++++++++++
 tb/tb_cache_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_types.sv
// Shared types and defaults for the I-cache / D-cache to pmem arbiter.
package arb_types;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_t;

endpackage

// File: rtl/arb_checker.sv
// Protocol checks for the arbiter's requester ports (simulation only).
module arb_checker (
  input logic clk,
  input logic rst_n,
  input logic a_read,
  input logic a_write,
  input logic b_read,
  input logic b_write
);

  // A port may ask for a read or a write, never both at once.
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(a_read && a_write));
  b_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(b_read && b_write));

endmodule

// File: rtl/arb_select.sv
// Combinational winner choice between the I-cache (A) and D-cache (B) requests.
// Build option: define ARB_ROUND_ROBIN_EN to break ties against the last granted
// port; otherwise ties always go to B (data side).
module arb_select
  import arb_types::*;
(
  input  logic      req_a_i,
  input  logic      req_b_i,
  input  arb_port_t last_i,
  output logic      valid_o,
  output arb_port_t win_o
);

`ifndef ARB_ROUND_ROBIN_EN
  // The pointer is still tracked by the top; it simply has no say here.
  arb_port_t last_unused_s;
  assign last_unused_s = last_i;
`endif

  // Pick a winner; a lone requester always wins, ties follow the build option.
  always_comb begin
    valid_o = req_a_i | req_b_i;
    win_o   = PORT_A;
    if (req_a_i && req_b_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_o = (last_i == PORT_A) ? PORT_B : PORT_A;
`else
      win_o = PORT_B;
`endif
    end else if (req_b_i) begin
      win_o = PORT_B;
    end else begin
      win_o = PORT_A;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: merges I-cache (A) and D-cache (B) line fills / writebacks onto
// one pmem port. The winner's command is captured in registers for the whole
// transaction; the pmem response is routed back to the granted port only.
// Build option: ARB_ROUND_ROBIN_EN (see arb_select) selects round-robin ties.
module cache_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [LINE_W-1:0] a_wdata,
  output logic [LINE_W-1:0] a_rdata,
  output logic              a_resp,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [LINE_W-1:0] b_wdata,
  output logic [LINE_W-1:0] b_rdata,
  output logic              b_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q, state_d;
  arb_port_t         last_q, last_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wd_q, wd_d;
  logic              win_valid_s;
  arb_port_t         win_port_s;

  arb_select u_select (
    .req_a_i (a_read | a_write),
    .req_b_i (b_read | b_write),
    .last_i  (last_q),
    .valid_o (win_valid_s),
    .win_o   (win_port_s)
  );

  arb_checker u_checker (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_read  (a_read),
    .a_write (a_write),
    .b_read  (b_read),
    .b_write (b_write)
  );

  // Next-state: grant and capture in IDLE, hold the command until pmem_resp.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          if (win_port_s == PORT_B) begin
            rd_d    = b_read;
            wr_d    = b_write & ~b_read;   // read wins an illegal read+write
            addr_d  = b_address;
            wd_d    = b_wdata;
            state_d = BUSY_B;
          end else begin
            rd_d    = a_read;
            wr_d    = a_write & ~a_read;
            addr_d  = a_address;
            wd_d    = a_wdata;
            state_d = BUSY_A;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_A: begin
        if (pmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          last_d  = PORT_A;
          state_d = IDLE;
        end else begin
          state_d = BUSY_A;
        end
      end
      BUSY_B: begin
        if (pmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          last_d  = PORT_B;
          state_d = IDLE;
        end else begin
          state_d = BUSY_B;
        end
      end
      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, grant pointer and pmem command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= PORT_A;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wd_q;

  // Response pass-through to the granted port only; the other port sees zeros.
  assign a_resp  = (state_q == BUSY_A) & pmem_resp;
  assign b_resp  = (state_q == BUSY_B) & pmem_resp;
  assign a_rdata = (state_q == BUSY_A) ? pmem_rdata : '0;
  assign b_rdata = (state_q == BUSY_B) ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expected pmem commands and
// port responses; a negedge monitor pops and compares when the DUT presents them.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_read = 1'b0, a_write = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [AW-1:0] a_address = '0, b_address = '0;
  logic [LW-1:0] a_wdata = '0, b_wdata = '0;
  logic [LW-1:0] a_rdata, b_rdata;
  logic          a_resp, b_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_resp(a_resp),
    .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_resp(b_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wd;
  } cmd_t;

  typedef struct {
    logic          port_b;
    logic [LW-1:0] rd;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: compare each new pmem command and each port response with the scoreboard.
  logic cmd_prev = 1'b0;
  always @(negedge clk) begin : monitor
    cmd_t  c;
    resp_t r;
    if (rst_n) begin
      if ((pmem_read | pmem_write) && !cmd_prev) begin
        if (cmd_q.size() == 0) begin
          fail_now("unexpected_cmd", "pmem command with nothing expected");
        end else begin
          c = cmd_q.pop_front();
          chk_b("cmd_read", pmem_read, c.rd);
          chk_b("cmd_write", pmem_write, c.wr);
          chk_a("cmd_addr", pmem_address, c.addr);
          chk_d("cmd_wdata", pmem_wdata, c.wd);
        end
      end
      if (a_resp || b_resp) begin
        if (a_resp && b_resp) fail_now("dual_resp", "a_resp and b_resp together");
        if (resp_q.size() == 0) begin
          fail_now("unexpected_resp", "port resp with nothing expected");
        end else begin
          r = resp_q.pop_front();
          chk_b("resp_port", b_resp, r.port_b);
          chk_d("resp_rdata", b_resp ? b_rdata : a_rdata, r.rd);
        end
      end
    end
    cmd_prev = pmem_read | pmem_write;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic rd, input logic wr, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wd);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = addr; c.wd = wd;
    cmd_q.push_back(c);
  endtask

  task automatic wait_cmd(input string name);
    int k = 0;
    while (!(pmem_read | pmem_write) && k < 20) begin
      tick();
      k++;
    end
    if (!(pmem_read | pmem_write)) fail_now(name, "timeout waiting for pmem command");
  endtask

  // One-cycle pmem_resp pulse; optionally drop requests in the resp cycle.
  task automatic do_resp(input logic port_b, input logic [LW-1:0] rd,
                         input logic drop_a, input logic drop_b);
    resp_t r;
    r.port_b = port_b; r.rd = rd;
    resp_q.push_back(r);
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    if (drop_a) begin a_read = 1'b0; a_write = 1'b0; end
    if (drop_b) begin b_read = 1'b0; b_write = 1'b0; end
    @(negedge clk);
    if (port_b) begin
      chk_b("other_resp_a", a_resp, 1'b0);
      chk_d("other_rdata_a", a_rdata, {LW{1'b0}});
    end else begin
      chk_b("other_resp_b", b_resp, 1'b0);
      chk_d("other_rdata_b", b_rdata, {LW{1'b0}});
    end
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  task automatic do_reset();
    a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
    pmem_resp = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_b("rst_pmem_read", pmem_read, 1'b0);
    chk_b("rst_pmem_write", pmem_write, 1'b0);
    chk_a("rst_pmem_address", pmem_address, {AW{1'b0}});
    chk_d("rst_pmem_wdata", pmem_wdata, {LW{1'b0}});
    chk_b("rst_a_resp", a_resp, 1'b0);
    chk_b("rst_b_resp", b_resp, 1'b0);
    chk_d("rst_a_rdata", a_rdata, {LW{1'b0}});
    chk_d("rst_b_rdata", b_rdata, {LW{1'b0}});
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: single A read, one-cycle grant latency, response routed to A only
    do_reset();
    a_read = 1'b1; a_address = 32'h0000_0060;
    push_cmd(1'b1, 1'b0, 32'h0000_0060, {LW{1'b0}});
    @(negedge clk);
    chk_b("t1_latency_not_yet", pmem_read, 1'b0);
    tick();
    chk_b("t1_cmd_up", pmem_read, 1'b1);
    do_resp(1'b0, {32{8'hAB}}, 1'b1, 1'b0);
    chk_b("t1_read_cleared", pmem_read, 1'b0);

    // 2: simultaneous requests after reset, then B re-requests immediately
    do_reset();
    a_read = 1'b1; a_address = 32'h0000_1000;
    b_read = 1'b1; b_address = 32'h0000_2000;
    push_cmd(1'b1, 1'b0, 32'h0000_2000, {LW{1'b0}});
    wait_cmd("t2_first");
    do_resp(1'b1, {32{8'h11}}, 1'b0, 1'b1);
    push_cmd(1'b1, 1'b0, 32'h0000_1000, {LW{1'b0}});
    wait_cmd("t2_second");
    do_resp(1'b0, {32{8'h22}}, 1'b1, 1'b0);
    a_read = 1'b1; a_address = 32'h0000_1100;
    b_read = 1'b1; b_address = 32'h0000_2100;
    push_cmd(1'b1, 1'b0, 32'h0000_2100, {LW{1'b0}});
    wait_cmd("t2_third");
    do_resp(1'b1, {32{8'h33}}, 1'b0, 1'b1);
    b_read = 1'b1; b_address = 32'h0000_2200;
`ifdef ARB_ROUND_ROBIN_EN
    push_cmd(1'b1, 1'b0, 32'h0000_1100, {LW{1'b0}});
    wait_cmd("t2_rr_a");
    do_resp(1'b0, {32{8'h44}}, 1'b1, 1'b0);
    push_cmd(1'b1, 1'b0, 32'h0000_2200, {LW{1'b0}});
    wait_cmd("t2_rr_b");
    do_resp(1'b1, {32{8'h55}}, 1'b0, 1'b1);
`else
    push_cmd(1'b1, 1'b0, 32'h0000_2200, {LW{1'b0}});
    wait_cmd("t2_fp_b");
    do_resp(1'b1, {32{8'h55}}, 1'b0, 1'b1);
    push_cmd(1'b1, 1'b0, 32'h0000_1100, {LW{1'b0}});
    wait_cmd("t2_fp_a");
    do_resp(1'b0, {32{8'h44}}, 1'b1, 1'b0);
`endif

    // 3: B write command held while the requester changes its inputs
    b_write = 1'b1; b_address = 32'h0000_0100; b_wdata = {32{8'h5A}};
    push_cmd(1'b0, 1'b1, 32'h0000_0100, {32{8'h5A}});
    wait_cmd("t3_write");
    b_address = 32'h0000_0200; b_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("t3_hold_addr", pmem_address, 32'h0000_0100);
      chk_d("t3_hold_wdata", pmem_wdata, {32{8'h5A}});
      chk_b("t3_hold_write", pmem_write, 1'b1);
    end
    do_resp(1'b1, {LW{1'b0}}, 1'b0, 1'b1);

    // 4: async reset two cycles into BUSY_A abandons the transaction
    a_read = 1'b1; a_address = 32'h0000_0300;
    push_cmd(1'b1, 1'b0, 32'h0000_0300, {LW{1'b0}});
    wait_cmd("t4_cmd");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_b("t4_async_drop", pmem_read, 1'b0);
    a_read = 1'b0;
    @(negedge clk);
    chk_b("t4_no_a_resp", a_resp, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // 5: stray pmem_resp in IDLE is not forwarded
    pmem_resp = 1'b1; pmem_rdata = {32{8'hFF}};
    @(negedge clk);
    chk_b("t5_a_resp", a_resp, 1'b0);
    chk_b("t5_b_resp", b_resp, 1'b0);
    chk_d("t5_a_rdata", a_rdata, {LW{1'b0}});
    chk_d("t5_b_rdata", b_rdata, {LW{1'b0}});
    tick();
    pmem_resp = 1'b0; pmem_rdata = '0;
    // FSM must still be in IDLE: a new request is granted after exactly one cycle
    b_read = 1'b1; b_address = 32'h0000_0400;
    push_cmd(1'b1, 1'b0, 32'h0000_0400, {LW{1'b0}});
    @(negedge clk);
    chk_b("t5_idle_latency0", pmem_read, 1'b0);
    tick();
    chk_b("t5_idle_latency1", pmem_read, 1'b1);
    do_resp(1'b1, {32{8'h66}}, 1'b0, 1'b1);

    // 6: A requests continuously, B arrives during BUSY_A and is served next
    do_reset();
    a_read = 1'b1; a_address = 32'h0000_0500;
    push_cmd(1'b1, 1'b0, 32'h0000_0500, {LW{1'b0}});
    wait_cmd("t6_a");
    b_read = 1'b1; b_address = 32'h0000_0600;
    tick();
    push_cmd(1'b1, 1'b0, 32'h0000_0600, {LW{1'b0}});
    do_resp(1'b0, {32{8'h77}}, 1'b0, 1'b0);
    wait_cmd("t6_b");
    do_resp(1'b1, {32{8'h88}}, 1'b0, 1'b1);
    push_cmd(1'b1, 1'b0, 32'h0000_0500, {LW{1'b0}});
    wait_cmd("t6_a_again");
    do_resp(1'b0, {32{8'h99}}, 1'b1, 1'b0);

    tick();
    tick();
    chk_a("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    chk_a("resp_queue_drained", 32'(resp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
